uart_tx_feeder: RTL

Byte-buffering front end that sits directly upstream of the UART transmitter core. It accepts bytes on a valid/ready interface into a synchronous FIFO. It then launches them one at a time into the transmitter through its start/data/active/done handshake. The host can queue a burst without tracking per-byte transmitter timing; the serial line carries bytes back-to-back with only the handshake turnaround between frames.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_sync_fifo.sv | 74 +++++++
 rtl/uart_tx_feeder.sv | 105 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit scheduler states and default bit timing.
package uart_pkg;

    localparam int CLOCKS_PER_BIT = 868;
    localparam int BYTE_W         = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACT  = 2'd1,
        WAIT_DONE = 2'd2
    } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with occupancy count, sticky overflow flag and single-cycle flush.
module uart_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             push_req,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count,
    output logic             overflow
);

    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             overflow_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count_reg == DEPTH_CNT);
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign overflow = overflow_reg;
    assign rd_data  = mem[rd_ptr_reg];

    // A push coinciding with a flush is discarded along with the old contents.
    assign push_ok = push_req && !full && !flush;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            overflow_reg <= 1'b0;
        end else if (push_req && full) begin
            overflow_reg <= 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Queues host bytes and launches them one at a time into the UART transmitter.
// Define UART_TX_FEEDER_LEVEL_EN to add level_o (FIFO occupancy) and flush_i.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [BYTE_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic              tx_start_o,
    output logic [BYTE_W-1:0] tx_data_o,
    input  logic              tx_active_i,
    input  logic              tx_done_i,
    output logic              busy_o,
    output logic              overflow_o
`ifdef UART_TX_FEEDER_LEVEL_EN
    ,
    input  logic              flush_i,
    output logic [AW:0]       level_o
`endif
);

    tx_state_e         state_reg;
    logic              tx_start_reg;
    logic [BYTE_W-1:0] tx_data_reg;

    logic              fifo_flush;
    logic              fifo_pop;
    logic [BYTE_W-1:0] fifo_rd_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic [AW:0]       fifo_count;

`ifdef UART_TX_FEEDER_LEVEL_EN
    assign fifo_flush = flush_i;
    assign level_o    = fifo_count;
`else
    assign fifo_flush = 1'b0;
`endif

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .flush    (fifo_flush),
        .push_req (in_valid_i),
        .wr_data  (in_data_i),
        .pop      (fifo_pop),
        .rd_data  (fifo_rd_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .overflow (overflow_o)
    );

    // The head byte leaves the FIFO in the same cycle it is latched into tx_data_o.
    assign fifo_pop   = (state_reg == IDLE) && !fifo_empty;
    assign in_ready_o = !fifo_full;
    assign busy_o     = (state_reg != IDLE) || (fifo_count != '0);
    assign tx_start_o = tx_start_reg;
    assign tx_data_o  = tx_data_reg;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg    <= IDLE;
            tx_start_reg <= 1'b0;
            tx_data_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!fifo_empty) begin
                        tx_data_reg  <= fifo_rd_data;
                        tx_start_reg <= 1'b1;
                        state_reg    <= WAIT_ACT;
                    end else begin
                        tx_start_reg <= 1'b0;
                    end
                end
                WAIT_ACT: begin
                    tx_start_reg <= 1'b0;
                    if (tx_active_i) begin
                        state_reg <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    tx_start_reg <= 1'b0;
                    if (tx_done_i) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    tx_start_reg <= 1'b0;
                    state_reg    <= IDLE;
                end
            endcase
        end
    end

endmodule
